// File: rtl/gray_seq_src.sv
// gray_seq_src: registered binary/Gray sequence source feeding the deco48
// one-hot decoder. Holds a binary count and presents it, together with its
// Gray code, behind a valid/ready handshake. Supports load, up/down counting,
// a one-cycle wrap pulse and drain-to-idle.
// Optional Gray-adjacency checker: define GRAY_SEQ_CHECK_EN to build it;
// otherwise gray_err is tied low.
module gray_seq_src #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             dir,
  input  logic             halt,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] gray_out,
  output logic [WIDTH-1:0] bin_out,
  output logic             wrap,
  output logic             gray_err
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACTIVE = 2'd1;
  localparam logic [1:0] ST_DRAIN  = 2'd2;

  localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);
  localparam logic [WIDTH-1:0] CNT_MAX = '1;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] bin_q, bin_d;
  logic [WIDTH-1:0] gray_q, gray_d;
  logic             wrap_q, wrap_d;
  logic             accept;
  logic             advance;

  assign out_valid = (state_q != ST_IDLE);
  assign accept    = out_valid & out_ready;

  // Next state and next count: load > halt > count while active.
  // NOTE: every signal assigned here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    advance = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (load) begin
          state_d = ST_ACTIVE;
          bin_d   = load_val;
        end else if (en) begin
          state_d = ST_ACTIVE;
          bin_d   = '0;
        end
      end
      ST_ACTIVE: begin
        if (load) begin
          bin_d = load_val;               // current value dropped if unaccepted
        end else if (halt) begin
          state_d = ST_DRAIN;
        end else if (en && accept) begin
          advance = 1'b1;
          bin_d   = dir ? (bin_q + CNT_ONE) : (bin_q - CNT_ONE);
        end
      end
      ST_DRAIN: begin
        if (load) begin
          state_d = ST_ACTIVE;
          bin_d   = load_val;
        end else if (accept) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    wrap_d = advance & (dir ? (bin_q == CNT_MAX) : (bin_q == '0));
    gray_d = bin_d ^ (bin_d >> 1);
  end

  // State, count, Gray code and wrap pulse registers (synchronous reset).
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      bin_q   <= '0;
      gray_q  <= '0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      gray_q  <= gray_d;
      wrap_q  <= wrap_d;
    end
  end

  assign bin_out  = bin_q;
  assign gray_out = gray_q;
  assign wrap     = wrap_q;

`ifdef GRAY_SEQ_CHECK_EN
  logic [WIDTH-1:0] gray_diff;
  logic             one_bit_step;
  logic             err_q;

  assign gray_diff    = gray_q ^ gray_d;
  assign one_bit_step = (gray_diff != '0) && ((gray_diff & (gray_diff - CNT_ONE)) == '0);

  // Sticky flag: a counting advance whose Gray codes differ in other than one bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (advance && !one_bit_step) begin
      err_q <= 1'b1;
    end
  end

  assign gray_err = err_q;
`else
  assign gray_err = 1'b0;
`endif

endmodule
